bcd_countdown_timer: RTL and testbench

- Two-digit BCD down-counter (99..00) with load, start, pause/resume and a done indication. It is the countdown counterpart of the board's up-counting BCD display counter.
- `tens`/`ones` feed the existing per-digit seven-segment decoders directly.
- `blink` drives an LED while expired.
- Count rate comes from an internal prescaler on the single system clock.

---
 rtl/bcd_countdown_timer_if.sv | 17 +
 rtl/bcd_countdown_timer.sv | 82 ++++++++
 tb/tb_bcd_countdown_timer.sv | 102 ++++++++++
 3 files changed

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: control inputs and digit/status outputs of the countdown timer
interface bcd_countdown_timer_if;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       blink;
  modport master (output load, load_tens, load_ones, start, pause,
                  input  tens, ones, running, done, blink);
  modport slave  (input  load, load_tens, load_ones, start, pause,
                  output tens, ones, running, done, blink);
endinterface

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: two-digit BCD down-counter with load/start/pause, done flag and blink
module bcd_countdown_timer #(
  parameter int TICK_DIV = 10_000_000,
  parameter int CNT_W    = 24
) (
  input logic                  clock,
  input logic                  reset,
  bcd_countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state, state_n;
  logic [3:0] tens_q, ones_q, tens_n, ones_n;
  logic [CNT_W-1:0] pre, pre_n, pre_inc;
  logic blink_q, blink_n, tick, zero, last;
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return d > 4'd9 ? 4'd9 : d;
  endfunction
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      tens_q  <= '0;
      ones_q  <= '0;
      pre     <= '0;
      blink_q <= 1'b0;
    end else begin
      state   <= state_n;
      tens_q  <= tens_n;
      ones_q  <= ones_n;
      pre     <= pre_n;
      blink_q <= blink_n;
    end
  end
  // last: the decrement about to happen lands on 00
  always_comb begin
    state_n = state;
    tens_n  = tens_q;
    ones_n  = ones_q;
    pre_n   = pre;
    blink_n = blink_q;
    tick    = pre == CNT_W'(TICK_DIV - 1);
    pre_inc = tick ? '0 : pre + 1'b1;
    zero    = tens_q == 4'd0 && ones_q == 4'd0;
    last    = tens_q == 4'd0 && ones_q == 4'd1;
    if (bus.load && state != RUN) begin
      state_n = IDLE;
      tens_n  = clamp9(bus.load_tens);
      ones_n  = clamp9(bus.load_ones);
      pre_n   = '0;
      blink_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state_n = zero ? DONE : RUN;
          pre_n   = '0;
        end
        PAUSED: if (bus.start) begin
          state_n = zero ? DONE : RUN;
          pre_n   = zero ? '0 : pre;
        end
        RUN: if (bus.pause) state_n = PAUSED;
        else begin
          pre_n = pre_inc;
          if (tick && !zero) begin
            ones_n  = ones_q != 4'd0 ? ones_q - 4'd1 : 4'd9;
            tens_n  = ones_q != 4'd0 ? tens_q : tens_q - 4'd1;
            state_n = last ? DONE : RUN;
          end
        end
        DONE: begin
          pre_n   = pre_inc;
          blink_n = tick ? ~blink_q : blink_q;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  assign bus.tens    = tens_q;
  assign bus.ones    = ones_q;
  assign bus.running = state == RUN;
  assign bus.done    = state == DONE;
  assign bus.blink   = blink_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed scoreboard bench for bcd_countdown_timer with TICK_DIV=4
module tb_bcd_countdown_timer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  bcd_countdown_timer_if bus();
  bcd_countdown_timer #(.TICK_DIV(4), .CNT_W(3)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {string tag; logic [10:0] val;} exp_t;
  exp_t q[$];
  int passed = 0;
  int total = 0;
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic ld, input logic [3:0] lt, input logic [3:0] lo, input logic st, input logic pa);
    bus.load = ld; bus.load_tens = lt; bus.load_ones = lo; bus.start = st; bus.pause = pa;
    step(1);
    bus.load = 0; bus.load_tens = 0; bus.load_ones = 0; bus.start = 0; bus.pause = 0;
  endtask
  // expected {tens,ones,running,done,blink} after n more cycles
  task automatic chk(input string tag, input int n, input logic [3:0] t, input logic [3:0] o,
                     input logic r, input logic d, input logic b);
    exp_t e;
    logic [10:0] obs;
    q.push_back('{tag, {t, o, r, d, b}});
    step(n);
    e = q.pop_front();
    obs = {bus.tens, bus.ones, bus.running, bus.done, bus.blink};
    total++;
    assert (obs === e.val) passed++;
    else $error("FAIL %s: observed t=%h o=%h r=%b d=%b b=%b expected t=%h o=%h r=%b d=%b b=%b",
                e.tag, obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
                e.val[10:7], e.val[6:3], e.val[2], e.val[1], e.val[0]);
  endtask
  initial begin
    bus.load = 0; bus.load_tens = 0; bus.load_ones = 0; bus.start = 0; bus.pause = 0;
    step(2);
    reset = 0;
    chk("reset", 0, 0, 0, 0, 0, 0);
    drive(1, 2, 5, 0, 0);
    chk("load25", 0, 2, 5, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("start25", 0, 2, 5, 1, 0, 0);
    chk("before_tick", 3, 2, 5, 1, 0, 0);
    chk("dec24", 1, 2, 4, 1, 0, 0);
    chk("borrow19", 20, 1, 9, 1, 0, 0);
    drive(1, 7, 7, 0, 0);
    chk("load_in_run", 0, 1, 9, 1, 0, 0);
    chk("dec18", 3, 1, 8, 1, 0, 0);
    drive(0, 0, 0, 1, 1);
    chk("pause_wins", 0, 1, 8, 0, 0, 0);
    drive(1, 0, 2, 0, 0);
    chk("load02", 0, 0, 2, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("start02", 0, 0, 2, 1, 0, 0);
    chk("dec01", 4, 0, 1, 1, 0, 0);
    chk("done00", 4, 0, 0, 0, 1, 0);
    chk("blink_wait", 3, 0, 0, 0, 1, 0);
    chk("blink1", 1, 0, 0, 0, 1, 1);
    chk("blink0", 4, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("start_in_done", 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    chk("pause_in_done", 0, 0, 0, 0, 1, 0);
    drive(1, 4'hA, 4'hF, 0, 0);
    chk("clamp99", 0, 9, 9, 0, 0, 0);
    drive(1, 3, 4'hC, 0, 0);
    chk("clamp39", 0, 3, 9, 0, 0, 0);
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("dec49", 4, 4, 9, 1, 0, 0);
    chk("pre2", 2, 4, 9, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("paused49", 0, 4, 9, 0, 0, 0);
    chk("hold49", 20, 4, 9, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("resume", 1, 4, 9, 1, 0, 0);
    chk("dec48", 1, 4, 8, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("paused48", 0, 4, 8, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("load00", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("start00_done", 0, 0, 0, 0, 1, 0);
    chk("blink_after00", 4, 0, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 0);
    chk("load10_from_done", 0, 1, 0, 0, 0, 0);
    drive(1, 3, 7, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("run37", 2, 3, 7, 1, 0, 0);
    reset = 1;
    step(1);
    reset = 0;
    chk("reset_mid", 0, 0, 0, 0, 0, 0);
    chk("idle_holds", 4, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("start00_after_reset", 0, 0, 0, 0, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
